// File: rtl/alu_arbiter_if.sv
// ALU op encoding plus the requester/response bundle between the shared-ALU
// arbiter (slave) and its requesters/response consumer (master).

package alu_pkg;
   typedef enum logic [3:0] {
      ALU_NOOP          = 4'd0,
      ALU_ADD           = 4'd1,
      ALU_SUB           = 4'd2,
      ALU_AND           = 4'd3,
      ALU_OR            = 4'd4,
      ALU_XOR           = 4'd5,
      ALU_SLL           = 4'd6,
      ALU_SRL           = 4'd7,
      ALU_SRA           = 4'd8,
      ALU_LESS_SIGNED   = 4'd9,
      ALU_LESS_UNSIGNED = 4'd10,
      ALU_EQUAL         = 4'd11,
      ALU_XY_ADD        = 4'd12,
      ALU_XY_SUB        = 4'd13
   } alu_control_t;
endpackage

interface alu_arbiter_if #(
   parameter int N_REQ = 4
) ();
   localparam int ID_W = $clog2(N_REQ);

   // request side, one slot per requester
   logic [N_REQ-1:0]                    req_valid;
   logic [N_REQ-1:0]                    req_ready;
   logic [N_REQ-1:0][31:0]              req_src_a;
   logic [N_REQ-1:0][31:0]              req_src_b;
   alu_pkg::alu_control_t [N_REQ-1:0]   req_control;
   logic [N_REQ-1:0]                    req_invert_cond;

   // tagged response side
   logic                                rsp_valid;
   logic                                rsp_ready;
   logic [ID_W-1:0]                     rsp_id;
   logic [31:0]                         rsp_result;
   logic                                rsp_take_branch;

   modport master (
      output req_valid, req_src_a, req_src_b, req_control, req_invert_cond,
      input  req_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_take_branch,
      output rsp_ready
   );

   modport slave (
      input  req_valid, req_src_a, req_src_b, req_control, req_invert_cond,
      output req_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_take_branch,
      input  rsp_ready
   );
endinterface

// File: rtl/alu_arbiter.sv
// Shared-ALU front end: round-robin arbitration of N_REQ requesters into an
// issue register that drives a combinational ALU, whose outputs are captured
// in a tagged result register with valid/ready backpressure.
// Also holds the combinational ALU the arbiter is paired with.

module alu (
   input  logic [31:0]           src_a,
   input  logic [31:0]           src_b,
   input  alu_pkg::alu_control_t control,
   input  logic                  invert_cond,
   output logic [31:0]           result,
   output logic                  take_branch
);
   import alu_pkg::*;

   logic is_cmp;
   logic cond;

   // op decode; unknown encodings and NOOP return zero and never branch
   always_comb begin
      result = '0;
      is_cmp = 1'b0;
      cond   = 1'b0;
      case (control)
         ALU_ADD:           result = src_a + src_b;
         ALU_SUB:           result = src_a - src_b;
         ALU_AND:           result = src_a & src_b;
         ALU_OR:            result = src_a | src_b;
         ALU_XOR:           result = src_a ^ src_b;
         ALU_SLL:           result = src_a << src_b[4:0];
         ALU_SRL:           result = src_a >> src_b[4:0];
         ALU_SRA:           result = $signed(src_a) >>> src_b[4:0];
         ALU_LESS_SIGNED: begin
            is_cmp = 1'b1;
            cond   = $signed(src_a) < $signed(src_b);
            result = {31'd0, cond};
         end
         ALU_LESS_UNSIGNED: begin
            is_cmp = 1'b1;
            cond   = src_a < src_b;
            result = {31'd0, cond};
         end
         ALU_EQUAL: begin
            is_cmp = 1'b1;
            cond   = src_a == src_b;
            result = {31'd0, cond};
         end
         // packed 16-bit X/Y pairs; each half wraps on its own
         ALU_XY_ADD:        result = {src_a[31:16] + src_b[31:16], src_a[15:0] + src_b[15:0]};
         ALU_XY_SUB:        result = {src_a[31:16] - src_b[31:16], src_a[15:0] - src_b[15:0]};
         default:           result = '0;
      endcase
      take_branch = is_cmp & (cond ^ invert_cond);
   end
endmodule

module alu_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_arbiter_if.slave          bus,
   output logic [31:0]           alu_src_a,
   output logic [31:0]           alu_src_b,
   output alu_pkg::alu_control_t alu_control,
   output logic                  alu_invert_cond,
   input  logic [31:0]           alu_result,
   input  logic                  alu_take_branch,
   output logic                  busy
);
   import alu_pkg::*;

   localparam int ID_W = $clog2(N_REQ);

   logic            iss_valid;
   logic [ID_W-1:0] iss_id;
   logic [ID_W-1:0] rr_ptr;

   logic            rsp_stall;
   logic            iss_adv;
   logic            iss_free;
   logic            win_found;
   logic [ID_W-1:0] win_idx;
   logic [ID_W-1:0] cand;
   logic            accept;

   assign rsp_stall = bus.rsp_valid & ~bus.rsp_ready;
   assign iss_adv   = ~rsp_stall;
   assign iss_free  = ~iss_valid | iss_adv;
   assign accept    = win_found & iss_free;
   assign busy      = iss_valid | bus.rsp_valid;

   // round-robin pick: first valid requester after the last one granted
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
         if (!win_found && bus.req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // ready goes only to the winner, and only when the issue slot can take it
   assign bus.req_ready = accept ? (N_REQ'(1) << win_idx) : '0;

   // issue stage: operand register feeding the ALU; holds when nothing new arrives
   always_ff @(posedge clk) begin
      if (rst) begin
         iss_valid       <= 1'b0;
         iss_id          <= '0;
         rr_ptr          <= ID_W'(N_REQ - 1);
         alu_src_a       <= '0;
         alu_src_b       <= '0;
         alu_control     <= ALU_NOOP;
         alu_invert_cond <= 1'b0;
      end else if (accept) begin
         iss_valid       <= 1'b1;
         iss_id          <= win_idx;
         rr_ptr          <= win_idx;
         alu_src_a       <= bus.req_src_a[win_idx];
         alu_src_b       <= bus.req_src_b[win_idx];
         alu_control     <= bus.req_control[win_idx];
         alu_invert_cond <= bus.req_invert_cond[win_idx];
      end else if (iss_adv) begin
         iss_valid       <= 1'b0;
      end
   end

   // result stage: capture ALU output unless the consumer is stalling us
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rsp_valid       <= 1'b0;
         bus.rsp_id          <= '0;
         bus.rsp_result      <= '0;
         bus.rsp_take_branch <= 1'b0;
      end else if (iss_valid && iss_adv) begin
         bus.rsp_valid       <= 1'b1;
         bus.rsp_id          <= iss_id;
         bus.rsp_result      <= alu_result;
         bus.rsp_take_branch <= alu_take_branch;
      end else if (bus.rsp_valid && bus.rsp_ready) begin
         bus.rsp_valid       <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter paired with the combinational alu.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int N_REQ = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [31:0]           alu_src_a, alu_src_b, alu_result;
   alu_control_t          alu_control;
   logic                  alu_invert_cond, alu_take_branch;
   logic                  busy;

   int n_chk = 0;
   int n_err = 0;

   alu_arbiter_if #(.N_REQ(N_REQ)) bus ();

   alu_arbiter #(.N_REQ(N_REQ)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .alu_src_a       (alu_src_a),
      .alu_src_b       (alu_src_b),
      .alu_control     (alu_control),
      .alu_invert_cond (alu_invert_cond),
      .alu_result      (alu_result),
      .alu_take_branch (alu_take_branch),
      .busy            (busy)
   );

   alu u_alu (
      .src_a       (alu_src_a),
      .src_b       (alu_src_b),
      .control     (alu_control),
      .invert_cond (alu_invert_cond),
      .result      (alu_result),
      .take_branch (alu_take_branch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   // single op from an otherwise idle arbiter; returns response fields
   task automatic run_op(input int idx, input alu_control_t ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic inv, input string tag,
                         output logic [31:0] res, output logic tkb, output logic [1:0] id);
      bit got_rsp = 0;
      int lat = 0;
      bus.req_valid[idx]       = 1'b1;
      bus.req_src_a[idx]       = a;
      bus.req_src_b[idx]       = b;
      bus.req_control[idx]     = ctl;
      bus.req_invert_cond[idx] = inv;
      @(negedge clk);
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'(N_REQ'(1) << idx));
      step();
      bus.req_valid[idx] = 1'b0;
      for (int n = 1; n <= 10 && !got_rsp; n++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            got_rsp = 1;
            lat = n;
         end
      end
      chk({tag, "_rsp_seen"}, 32'(got_rsp), 32'd1);
      chk({tag, "_latency"}, 32'(lat), 32'd2);
      res = bus.rsp_result;
      tkb = bus.rsp_take_branch;
      id  = bus.rsp_id;
      step();
   endtask

   logic [31:0] res;
   logic        tkb;
   logic [1:0]  id;
   int          accepts;

   initial begin
      rst = 1'b1;
      bus.req_valid       = '0;
      bus.req_src_a       = '0;
      bus.req_src_b       = '0;
      bus.req_control     = {N_REQ{ALU_NOOP}};
      bus.req_invert_cond = '0;
      bus.rsp_ready       = 1'b1;
      do_reset();

      // reset state
      @(negedge clk);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_result", bus.rsp_result, 0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 0);
      chk("rst_alu_ctl", 32'(alu_control), 32'(ALU_NOOP));
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      step();

      // single op: 5 + 7 from requester 2
      run_op(2, ALU_ADD, 32'd5, 32'd7, 1'b0, "single", res, tkb, id);
      chk("single_id", 32'(id), 2);
      chk("single_result", res, 32'd12);
      @(negedge clk);
      chk("single_drained", 32'(busy), 0);
      step();

      // round robin with all requesters continuously valid
      do_reset();
      for (int i = 0; i < N_REQ; i++) begin
         bus.req_src_a[i]   = 32'(i * 10);
         bus.req_src_b[i]   = 32'd1;
         bus.req_control[i] = ALU_ADD;
      end
      for (int k = 0; k < 10; k++) begin
         bus.req_valid = (k < 8) ? 4'hF : 4'h0;
         @(negedge clk);
         if (k < 8) chk($sformatf("rr_grant%0d", k), 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
         if (k >= 2) begin
            chk($sformatf("rr_rsp_id%0d", k), 32'(bus.rsp_id), 32'((k - 2) % 4));
            chk($sformatf("rr_rsp_res%0d", k), bus.rsp_result, 32'(((k - 2) % 4) * 10 + 1));
         end
         step();
      end

      // backpressure: two accepts fill the pipe, then ready drops
      bus.rsp_ready    = 1'b0;
      bus.req_src_a[0] = 32'd100; bus.req_src_b[0] = 32'd1;
      bus.req_src_a[1] = 32'd200; bus.req_src_b[1] = 32'd2;
      bus.req_valid    = 4'b0011;
      accepts = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         accepts += $countones(bus.req_valid & bus.req_ready);
         if (k >= 2) begin
            chk($sformatf("bp_ready%0d", k), 32'(bus.req_ready), 0);
            chk($sformatf("bp_hold_valid%0d", k), 32'(bus.rsp_valid), 1);
            chk($sformatf("bp_hold_id%0d", k), 32'(bus.rsp_id), 0);
            chk($sformatf("bp_hold_res%0d", k), bus.rsp_result, 32'd101);
         end
         step();
      end
      chk("bp_accepts", 32'(accepts), 2);
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_drain0_id", 32'(bus.rsp_id), 0);
      chk("bp_drain0_res", bus.rsp_result, 32'd101);
      step();
      @(negedge clk);
      chk("bp_drain1_valid", 32'(bus.rsp_valid), 1);
      chk("bp_drain1_id", 32'(bus.rsp_id), 1);
      chk("bp_drain1_res", bus.rsp_result, 32'd202);
      step();
      @(negedge clk);
      chk("bp_empty", 32'(busy), 0);
      step();

      // branch path through the EQUAL compare
      run_op(3, ALU_EQUAL, 32'd9, 32'd9, 1'b1, "br_inv", res, tkb, id);
      chk("br_inv_res", res, 32'd1);
      chk("br_inv_take", 32'(tkb), 0);
      chk("br_inv_id", 32'(id), 3);
      run_op(3, ALU_EQUAL, 32'd9, 32'd9, 1'b0, "br", res, tkb, id);
      chk("br_res", res, 32'd1);
      chk("br_take", 32'(tkb), 1);

      // reset with both stages full
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'hF;
      step();
      step();
      @(negedge clk);
      chk("mid_full_busy", 32'(busy), 1);
      rst = 1'b1;
      bus.req_valid = '0;
      step();
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("mid_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("mid_busy", 32'(busy), 0);
      for (int k = 0; k < 3; k++) begin
         step();
         @(negedge clk);
         chk($sformatf("mid_no_stale%0d", k), 32'(bus.rsp_valid), 0);
      end
      step();
      bus.req_valid = 4'hF;
      @(negedge clk);
      chk("mid_first_grant", 32'(bus.req_ready), 32'h1);
      step();
      bus.req_valid = '0;
      step();
      @(negedge clk);
      chk("mid_after_valid", 32'(bus.rsp_valid), 1);
      chk("mid_after_id", 32'(bus.rsp_id), 0);
      step();

      // packed X/Y subtract, per-half wrap
      run_op(1, ALU_XY_SUB, 32'h0001_0000, 32'h0002_0001, 1'b0, "xy", res, tkb, id);
      chk("xy_res", res, 32'hFFFF_FFFF);
      chk("xy_id", 32'(id), 1);

      // NOOP and an unused encoding still issue and return zero
      run_op(0, ALU_NOOP, 32'd3, 32'd4, 1'b0, "noop", res, tkb, id);
      chk("noop_res", res, 32'd0);
      run_op(2, alu_control_t'(4'hF), 32'd3, 32'd4, 1'b0, "unk", res, tkb, id);
      chk("unk_res", res, 32'd0);
      chk("unk_id", 32'(id), 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
